uart_byte_transmitter: RTL
==========================

Name: uart_byte_transmitter

Overview:
Drains bytes from an upstream byte FIFO and serialises each one onto a UART TX line: 8 data bits, LSB first, optional parity, 1 stop bit. It sits directly downstream of the directional byte buffer. It reads that buffer's occupancy count and head byte, and pops exactly one byte per frame.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit; integer >= 2
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
BUF_COUNT_WIDTH, 2, width of the upstream occupancy count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tx_enable  in  1  permits starting new frames
buf_count  in  BUF_COUNT_WIDTH  upstream buffer occupancy
buf_data  in  8  upstream head byte, combinational from buffer
buf_pop  out  1  pop strobe to upstream buffer (its output_en)
tx  out  1  serial line, idle high
busy  out  1  high while a frame is in progress
frame_done  out  1  1-cycle pulse in the last cycle of each stop bit

Behaviour:
- Interface conventions:
  - Reset: clock clk; reset is synchronous, active-high.
  - Reset values: tx=1, busy=0, buf_pop=0, frame_done=0, state=IDLE, baud counter=0, bit index=0.
- States: IDLE, START, DATA, PARITY (only when PARITY_MODE!=0), STOP.
- Pop condition: take = tx_enable && buf_count!=0 && (state==IDLE || (state==STOP && last stop cycle)).
  - buf_pop = take, combinational (Mealy) from registered state and buf_count only.
  - buf_pop must not depend on buf_data.
  - On the same edge, buf_data is latched into the shift register and state moves to START.
- tx is registered. START drives 0, DATA drives shift[0], PARITY drives the parity bit, STOP drives 1.
- Each state lasts exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and reloads 0 on every state change.
- DATA: 8 bits. Shift right at the end of each bit; the bit index counts 0..7.
- Parity bit:
  - even mode: XOR of the 8 latched bits
  - odd mode: its inverse
  - computed from the latched byte, not the live buf_data
- Latency: take at edge N, then tx=0 from cycle N+1. Frame length is exactly (10 + (PARITY_MODE!=0)) * CLKS_PER_BIT cycles.
- Back-to-back: if take is true in the last stop cycle, START follows immediately with no idle gap. frame_done still pulses in that cycle.
- busy: 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Empty buffer (buf_count==0): stay in IDLE, tx=1, buf_pop=0.
- tx_enable deasserted mid-frame: the current frame completes unchanged, and no further take occurs.
- Reset mid-frame: the next cycle is in reset state (tx=1). The partial frame is abandoned, and no pop is asserted during reset.
- buf_pop is never high for 2 consecutive cycles. It is high at most once per frame.

Decomposition:
- Package uart_pkg holds:
  - the state enum/localparams (IDLE, START, DATA, PARITY, STOP)
  - PARITY_NONE/EVEN/ODD constants
  - DATA_BITS=8
- Sub-module baud_tick_counter:
  - parameter CLKS_PER_BIT; inputs clk, reset, restart
  - output last_tick (high in the final cycle of a bit period)
  - counter width $clog2(CLKS_PER_BIT)

Test Plan:
1. CLKS_PER_BIT=4, PARITY_MODE=0, buffer holds 0x55, tx_enable=1:
   - one buf_pop pulse
   - tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4
   - frame_done in cycle 40 after pop; busy high 40 cycles
2. Buffer holds 0xA5 then 0x3C:
   - exactly 2 pops, 40 cycles apart
   - second start bit begins the cycle after the first stop bit ends, with no idle gap
   - 80 busy cycles total
3. buf_count=0 for 100 cycles: buf_pop never asserts, tx=1, busy=0. Then write 0x01: pop in the first cycle count!=0, and tx falls the next cycle.
4. PARITY_MODE=1, byte 0x07 -> parity bit 1, frame 44 cycles. PARITY_MODE=2, byte 0x07 -> parity bit 0.
5. Reset asserted in the DATA state bit 3 of 0xFF:
   - next cycle tx=1, busy=0, no pop during reset
   - after release with count=0, stays IDLE
6. tx_enable dropped during the first frame with 2 bytes queued: the first frame completes, frame_done pulses, the second byte is not popped (count stays 1), and tx stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
// State encoding, parity modes and frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

endpackage

// File: rtl/baud_tick_counter.sv
// Bit-period counter; last_tick marks the final cycle of each bit.
// restart forces the count back to zero on state changes and while idle.
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic last_tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign last_tick = (cnt == LAST);

endmodule

// File: rtl/uart_byte_transmitter.sv
// Pops bytes from an upstream FIFO and shifts them out as UART frames:
// start, 8 data bits LSB first, optional parity, one stop bit.
module uart_byte_transmitter #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int PARITY_MODE     = 0,
    parameter int BUF_COUNT_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_enable,
    input  logic [BUF_COUNT_WIDTH-1:0] buf_count,
    input  logic [7:0]                 buf_data,
    output logic                       buf_pop,
    output logic                       tx,
    output logic                       busy,
    output logic                       frame_done
);

    import uart_pkg::*;

    localparam logic HAS_PAR = (PARITY_MODE != PARITY_NONE);
    localparam logic PAR_INV = (PARITY_MODE == PARITY_ODD);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t state, state_d;

    logic [DATA_BITS-1:0] shift, shift_d;
    logic [BIT_IDX_W-1:0] bit_idx, bit_idx_d;
    logic                 par_bit;
    logic                 tx_d;
    logic                 take;
    logic                 last_tick;
    logic                 restart;

    baud_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .last_tick(last_tick)
    );

    // A new byte may be taken from idle or in the final cycle of a stop bit.
    always_comb begin
        take = tx_enable && !reset && (buf_count != '0) &&
               ((state == IDLE) || ((state == STOP) && last_tick));
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_idx_d = bit_idx;
        unique case (state)
            IDLE: begin
                if (take) state_d = START;
            end
            START: begin
                if (last_tick) state_d = DATA;
            end
            DATA: begin
                if (last_tick) begin
                    shift_d   = shift >> 1;
                    bit_idx_d = bit_idx + BIT_IDX_W'(1);
                    if (bit_idx == LAST_BIT) begin
                        state_d   = HAS_PAR ? PARITY : STOP;
                        bit_idx_d = '0;
                    end
                end
            end
            PARITY: begin
                if (last_tick) state_d = STOP;
            end
            STOP: begin
                if (last_tick) state_d = take ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take) shift_d = buf_data;
    end

    // tx is registered from the next state so the line moves with the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_idx <= bit_idx_d;
            tx      <= tx_d;
            if (take) par_bit <= (^buf_data) ^ PAR_INV;
        end
    end

    assign restart    = (state_d != state) || (state == IDLE);
    assign buf_pop    = take;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && last_tick;

endmodule
